hand_shake_pack: RTL and testbench
==================================

Name: hand_shake_pack

Overview:
- Downstream neighbour of the 8-bit valid/ready pipeline register.
- Packs RATIO consecutive narrow beats of WIDTH bits into one wide beat of WIDTH*RATIO bits.
- Supports early flush of a partial word on din_last, with a per-beat valid mask, and presents the result on a registered valid/ready output.
- Used to widen byte streams before bus-width consumers such as FIFOs and memory writers.

Parameters:
- WIDTH, 8, width of one input beat in bits.
- RATIO, 4, input beats per output word; legal range 2..16.
- CNT_W, $clog2(RATIO), local, width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- din  input  WIDTH  input beat data.
- din_vld  input  1  input beat valid.
- din_last  input  1  marks the final beat of a packet; qualified by din_vld.
- rdy_o  output  1  block can accept an input beat this cycle.
- dout  output  WIDTH*RATIO  packed output word.
- dout_mask  output  RATIO  bit k = 1 when beat slot k holds valid data.
- dout_last  output  1  output word closes a packet.
- vld_o  output  1  output word valid.
- rdy_i  input  1  downstream ready.

Behaviour:
- Reset: when rst_n = 0 at a clk edge, the following are cleared: vld_o = 0, dout = 0, dout_mask = 0, dout_last = 0, beat counter = 0, accumulator = 0. Reset mid-packet discards the partial word; the first beat after reset lands in slot 0.
- Handshake:
  - Input transfer when din_vld && rdy_o.
  - Output transfer when vld_o && rdy_i.
  - rdy_o = !vld_o || rdy_i, combinational from rdy_i.
  - rdy_o does not depend on din_vld or din_last.
- Slot placement: the beat accepted at counter value c is written to bits [c*WIDTH +: WIDTH]. Slot 0 occupies the LSBs.
- Completing beat: an accepted beat with counter == RATIO-1, or with din_last = 1.
- On a completing beat, at the same edge:
  - dout takes the accumulator with the current beat inserted; slots above c are forced to zero.
  - dout_mask = (2^(c+1))-1.
  - dout_last = din_last.
  - vld_o = 1.
  - Counter returns to 0 and the accumulator clears.
- On a non-completing accepted beat: the accumulator slot is written and the counter increments. Output registers are unaffected.
- Output hold: while vld_o && !rdy_i, dout, dout_mask and dout_last are stable and rdy_o = 0.
- Simultaneous drain and completion: an output transfer and a completing input beat in the same cycle give vld_o = 1 next cycle with the new word. Full throughput is one wide word per RATIO cycles, with no bubble.
- Drain without completion: an output transfer with no completing beat sets vld_o = 0 next cycle.
- Latency: the last beat of a word is accepted at edge N; the word is visible on dout at edge N (registered); the earliest output transfer is at edge N+1.
- din_last on slot RATIO-1: a normal full word with dout_last = 1.
- din_last on the first beat: a single-slot word with mask 0...01.
- Idle inputs: din, din_last and din_vld are ignored when no input transfer occurs. The accumulator persists indefinitely between beats; there is no timeout.

Optional Feature:
- Macro: HAND_SHAKE_PACK_MSB_FIRST_EN.
- When defined, slot c maps to bits [(RATIO-1-c)*WIDTH +: WIDTH]: the first beat lands in the MSBs, and dout_mask bit (RATIO-1-c) marks slot c. A flushed partial word is left-aligned in the MSBs and the unused low slots are zero.
- When undefined, the LSB-first mapping above applies.
- Handshake, timing and reset are identical in both builds.

Test Plan:
- Full-word pack: after reset, rdy_i = 1; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: one word, dout = 0x44332211, mask 0xF, last 0, vld_o high exactly 1 cycle.
- Partial flush: beats 0xA1, 0xB2 with din_last on 0xB2. Required: dout = 0x0000B2A1, mask 0x3, last 1. The next beat 0xC3 lands in slot 0.
- Backpressure: rdy_i = 0 for 5 cycles after a word forms. Required: rdy_o = 0, and dout/mask/last stable for all 5 cycles. When rdy_i rises, exactly one transfer occurs and no input beat is lost or duplicated.
- Streaming: 16 back-to-back beats 0x00..0x0F with rdy_i = 1. Required: 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, with no bubble on rdy_o.
- Reset mid-packet: accept 0x55, 0x66, then assert rst_n = 0 for 1 cycle. Required: vld_o = 0 and all outputs 0. Subsequent beats 0x01..0x04 give 0x04030201.
- MSB-first build: first test stimulus. Required: dout = 0x11223344. Flushing 0xA1, 0xB2 gives dout = 0xA1B20000, mask 0xC.

Source files
------------

// File: rtl/hand_shake_pack.sv
// Packs RATIO narrow valid/ready beats into one wide registered word.
// Define HAND_SHAKE_PACK_MSB_FIRST_EN to place the first beat in the MSBs.
module hand_shake_pack #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_vld,
    input  logic                   din_last,
    output logic                   rdy_o,
    output logic [WIDTH*RATIO-1:0] dout,
    output logic [RATIO-1:0]       dout_mask,
    output logic                   dout_last,
    output logic                   vld_o,
    input  logic                   rdy_i
);

    localparam int CNT_W = $clog2(RATIO);
    localparam int DW    = WIDTH * RATIO;

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [DW-1:0]    acc_q,  acc_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [RATIO-1:0] mask_q, mask_d;
    logic             last_q, last_d;
    logic             vld_q,  vld_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             complete;
    logic [DW-1:0]    ins;
    logic [DW-1:0]    word;
    logic [RATIO-1:0] mask_new;

    function automatic int slot_pos(input int c);
`ifdef HAND_SHAKE_PACK_MSB_FIRST_EN
        return RATIO - 1 - c;
`else
        return c;
`endif
    endfunction

    assign rdy_o     = !vld_q || rdy_i;
    assign dout      = dout_q;
    assign dout_mask = mask_q;
    assign dout_last = last_q;
    assign vld_o     = vld_q;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dout_d   = dout_q;
        mask_d   = mask_q;
        last_d   = last_q;
        vld_d    = vld_q;
        ins      = acc_q;
        word     = '0;
        mask_new = '0;

        in_xfer  = din_vld && rdy_o;
        out_xfer = vld_q && rdy_i;
        complete = in_xfer &&
                   ((cnt_q == CNT_W'(RATIO - 1)) || din_last);

        // Only slots up to the current beat survive into the word.
        for (int k = 0; k < RATIO; k++) begin
            if (k == int'(cnt_q)) begin
                ins[slot_pos(k)*WIDTH +: WIDTH] = din;
            end
            if (k <= int'(cnt_q)) begin
                word[slot_pos(k)*WIDTH +: WIDTH] =
                    ins[slot_pos(k)*WIDTH +: WIDTH];
                mask_new[slot_pos(k)] = 1'b1;
            end
        end

        if (out_xfer) begin
            vld_d = 1'b0;
        end

        if (complete) begin
            dout_d = word;
            mask_d = mask_new;
            last_d = din_last;
            vld_d  = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
        end else if (in_xfer) begin
            acc_d = ins;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            dout_q <= '0;
            mask_q <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            dout_q <= dout_d;
            mask_q <= mask_d;
            last_q <= last_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: tb/tb_hand_shake_pack.sv
// Directed bench for hand_shake_pack with a beat-queue reference model.
// Honours HAND_SHAKE_PACK_MSB_FIRST_EN for the literal expectations.
module tb_hand_shake_pack;

    localparam int W = 8;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          din_vld;
    logic          din_last;
    logic          rdy_o;
    logic [W*R-1:0] dout;
    logic [R-1:0]  dout_mask;
    logic          dout_last;
    logic          vld_o;
    logic          rdy_i;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    hand_shake_pack #(.WIDTH(W), .RATIO(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .din_last  (din_last),
        .rdy_o     (rdy_o),
        .dout      (dout),
        .dout_mask (dout_mask),
        .dout_last (dout_last),
        .vld_o     (vld_o),
        .rdy_i     (rdy_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: collect accepted beats, emit a word when full or last.
    function automatic int pos(input int i);
`ifdef HAND_SHAKE_PACK_MSB_FIRST_EN
        return R - 1 - i;
`else
        return i;
`endif
    endfunction

    int           q[$];
    bit           m_vld  = 1'b0;
    logic [31:0]  m_dout = '0;
    logic [3:0]   m_mask = '0;
    bit           m_last = 1'b0;

    always @(posedge clk) begin
        bit acc;
        bit drn;
        if (!rst_n) begin
            q.delete();
            m_vld  = 1'b0;
            m_dout = '0;
            m_mask = '0;
            m_last = 1'b0;
        end else begin
            acc = din_vld && (!m_vld || rdy_i);
            drn = m_vld && rdy_i;
            if (drn) m_vld = 1'b0;
            if (acc) begin
                q.push_back(int'(din));
                if (q.size() == R || din_last) begin
                    m_dout = '0;
                    m_mask = '0;
                    foreach (q[i]) begin
                        m_dout = m_dout | (32'(q[i]) << (pos(i) * W));
                        m_mask = m_mask | (4'b1 << pos(i));
                    end
                    m_last = din_last;
                    m_vld  = 1'b1;
                    q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_vld", 64'(vld_o), 64'(m_vld));
            check("cyc_rdy", 64'(rdy_o), 64'(!m_vld || rdy_i));
            if (m_vld) begin
                check("cyc_dout", 64'(dout), 64'(m_dout));
                check("cyc_mask", 64'(dout_mask), 64'(m_mask));
                check("cyc_last", 64'(dout_last), 64'(m_last));
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic l, output int waits);
        waits    = 0;
        din      = b;
        din_last = l;
        din_vld  = 1'b1;
        while (1) begin
            @(negedge clk);
            if (rdy_o) break;
            waits++;
            if (waits > 50) begin
                check("send_timeout", 64'(waits), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        din_vld  = 1'b0;
        din_last = 1'b0;
    endtask

`ifdef HAND_SHAKE_PACK_MSB_FIRST_EN
    localparam logic [31:0] E_FULL  = 32'h11223344;
    localparam logic [31:0] E_PART  = 32'hA1B20000;
    localparam logic [3:0]  E_PMSK  = 4'hC;
    localparam logic [31:0] E_ONE   = 32'hC3000000;
    localparam logic [3:0]  E_OMSK  = 4'h8;
    localparam logic [31:0] E_BP    = 32'h10111213;
    localparam logic [31:0] E_BP1   = 32'h20000000;
    localparam logic [31:0] E_RST   = 32'h01020304;
    localparam logic [31:0] E_STR[4] = '{32'h00010203, 32'h04050607,
                                         32'h08090A0B, 32'h0C0D0E0F};
`else
    localparam logic [31:0] E_FULL  = 32'h44332211;
    localparam logic [31:0] E_PART  = 32'h0000B2A1;
    localparam logic [3:0]  E_PMSK  = 4'h3;
    localparam logic [31:0] E_ONE   = 32'h000000C3;
    localparam logic [3:0]  E_OMSK  = 4'h1;
    localparam logic [31:0] E_BP    = 32'h13121110;
    localparam logic [31:0] E_BP1   = 32'h00000020;
    localparam logic [31:0] E_RST   = 32'h04030201;
    localparam logic [31:0] E_STR[4] = '{32'h03020100, 32'h07060504,
                                         32'h0B0A0908, 32'h0F0E0D0C};
`endif

    initial begin
        int w;
        logic [7:0] b;
        logic [7:0] full_beats[4];
        full_beats = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n    = 1'b0;
        din      = '0;
        din_vld  = 1'b0;
        din_last = 1'b0;
        rdy_i    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst_n  = 1'b1;
        check("rst_vld", 64'(vld_o), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_mask", 64'(dout_mask), 64'd0);
        check("rst_rdy", 64'(rdy_o), 64'd1);

        // Full-word pack
        for (int i = 0; i < 4; i++) send(full_beats[i], 1'b0, w);
        check("full_dout", 64'(dout), 64'(E_FULL));
        check("full_mask", 64'(dout_mask), 64'hF);
        check("full_last", 64'(dout_last), 64'd0);
        check("full_vld", 64'(vld_o), 64'd1);
        @(posedge clk);
        #1;
        check("full_vld_drop", 64'(vld_o), 64'd0);

        // Partial flush, then single-beat word lands in slot 0
        send(8'hA1, 1'b0, w);
        send(8'hB2, 1'b1, w);
        check("part_dout", 64'(dout), 64'(E_PART));
        check("part_mask", 64'(dout_mask), 64'(E_PMSK));
        check("part_last", 64'(dout_last), 64'd1);
        send(8'hC3, 1'b1, w);
        check("one_dout", 64'(dout), 64'(E_ONE));
        check("one_mask", 64'(dout_mask), 64'(E_OMSK));

        // Backpressure with a pending beat that must not be lost
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0, w);
        rdy_i = 1'b0;
        fork
            send(8'h20, 1'b1, w);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_rdy", 64'(rdy_o), 64'd0);
                    check("bp_dout", 64'(dout), 64'(E_BP));
                    check("bp_mask", 64'(dout_mask), 64'hF);
                    check("bp_last", 64'(dout_last), 64'd0);
                end
                @(posedge clk);
                #1;
                rdy_i = 1'b1;
            end
        join
        check("bp_next_dout", 64'(dout), 64'(E_BP1));
        check("bp_next_last", 64'(dout_last), 64'd1);
        check("bp_next_vld", 64'(vld_o), 64'd1);

        // Streaming 16 beats, no bubbles
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            send(b, 1'b0, w);
            check("str_wait", 64'(w), 64'd0);
            if (i % 4 == 3) begin
                check("str_dout", 64'(dout), 64'(E_STR[i/4]));
            end
        end

        // Reset mid-packet
        send(8'h55, 1'b0, w);
        send(8'h66, 1'b0, w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_vld", 64'(vld_o), 64'd0);
        check("mrst_dout", 64'(dout), 64'd0);
        check("mrst_mask", 64'(dout_mask), 64'd0);
        check("mrst_last", 64'(dout_last), 64'd0);
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, w);
        check("mrst_word", 64'(dout), 64'(E_RST));
        check("mrst_wmask", 64'(dout_mask), 64'hF);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
